// File: rtl/stage_skid_reg.sv
// Two-entry skid stage between pipeline stages: strict FIFO order, hold freezes the stage,
// and flush clears it and discards the next KILL_SHADOW upstream beats.
module stage_skid_reg #(
  parameter int                DATA_W      = 160,
  parameter int                KILL_SHADOW = 1,
  parameter logic [DATA_W-1:0] BUBBLE_VAL  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              hold,
  output logic [1:0]        occupancy,
  output logic              kill_pending
);

  localparam logic [2:0] KILL_LOAD = 3'(KILL_SHADOW);

  logic [DATA_W-1:0] head_q, head_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic [1:0]        occ_q, occ_d;
  logic [2:0]        kill_q, kill_d;
  logic              not_full, accept, drain, store;

  // Outputs are masked by rst so the reset values show during the reset cycle itself.
  assign not_full     = (occ_q != 2'd2);
  assign in_ready     = !rst && !hold && not_full;
  assign out_valid    = !rst && !hold && (occ_q != 2'd0);
  assign out_data     = (!rst && (occ_q != 2'd0)) ? head_q : BUBBLE_VAL;
  assign occupancy    = rst ? 2'd0 : occ_q;
  assign kill_pending = !rst && (kill_q != 3'd0);

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;
  assign store  = accept && (kill_q == 3'd0);

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    occ_d  = occ_q;
    kill_d = kill_q;
    if (flush) begin
      occ_d  = 2'd0;
      kill_d = KILL_LOAD;
    end else if (!hold) begin
      if (accept && (kill_q != 3'd0)) kill_d = kill_q - 3'd1;
      case (occ_q)
        2'd0: begin
          if (store) begin
            head_d = in_data;
            occ_d  = 2'd1;
          end
        end
        2'd1: begin
          if (drain && store) begin
            head_d = in_data;
          end else if (drain) begin
            occ_d = 2'd0;
          end else if (store) begin
            skid_d = in_data;
            occ_d  = 2'd2;
          end
        end
        default: begin
          // Full: in_ready is low, so only a drain can happen here.
          if (drain) begin
            head_d = skid_q;
            occ_d  = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      skid_q <= '0;
      occ_q  <= 2'd0;
      kill_q <= 3'd0;
    end else begin
      head_q <= head_d;
      skid_q <= skid_d;
      occ_q  <= occ_d;
      kill_q <= kill_d;
    end
  end

endmodule

// File: tb/tb_stage_skid_reg.sv
// Bench for stage_skid_reg: directed vector table, hand sequences and random traffic,
// three instances (shadow 1, 2, 0) checked against a FIFO-list reference model.
module tb_stage_skid_reg;
  localparam int W = 160;
  localparam int N = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, hold, in_valid, out_ready;
  logic [W-1:0] in_data;

  logic [N-1:0]        ir, ov, kp;
  logic [N-1:0][W-1:0] od;
  logic [N-1:0][1:0]   occ;

  stage_skid_reg #(.DATA_W(W), .KILL_SHADOW(1), .BUBBLE_VAL('0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ready(out_ready), .flush(flush),
    .hold(hold), .occupancy(occ[0]), .kill_pending(kp[0]));

  stage_skid_reg #(.DATA_W(W), .KILL_SHADOW(2), .BUBBLE_VAL(160'hBEEF)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ready(out_ready), .flush(flush),
    .hold(hold), .occupancy(occ[1]), .kill_pending(kp[1]));

  stage_skid_reg #(.DATA_W(W), .KILL_SHADOW(0), .BUBBLE_VAL(160'h5A5A)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(ir[2]),
    .out_valid(ov[2]), .out_data(od[2]), .out_ready(out_ready), .flush(flush),
    .hold(hold), .occupancy(occ[2]), .kill_pending(kp[2]));

  // Reference model: per instance a list of held payloads (oldest first) and a kill count.
  int           ks     [N] = '{1, 2, 0};
  logic [W-1:0] bubble [N] = '{160'h0, 160'hBEEF, 160'h5A5A};
  logic [W-1:0] mdat   [N][2];
  int           mcnt   [N];
  int           mkill  [N];

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic model_check();
    for (int i = 0; i < N; i++) begin
      chk($sformatf("occ[%0d]", i), W'(occ[i]), rst ? W'(0) : W'(mcnt[i]));
      chk($sformatf("in_ready[%0d]", i), W'(ir[i]), W'(!rst && !hold && mcnt[i] < 2));
      chk($sformatf("out_valid[%0d]", i), W'(ov[i]), W'(!rst && !hold && mcnt[i] > 0));
      chk($sformatf("out_data[%0d]", i), od[i], (!rst && mcnt[i] > 0) ? mdat[i][0] : bubble[i]);
      chk($sformatf("kill_pending[%0d]", i), W'(kp[i]), W'(!rst && mkill[i] > 0));
    end
  endtask

  task automatic model_update();
    bit acc, drn;
    for (int i = 0; i < N; i++) begin
      if (rst) begin
        mcnt[i] = 0; mkill[i] = 0;
      end else if (flush) begin
        mcnt[i] = 0; mkill[i] = ks[i];
      end else if (!hold) begin
        acc = in_valid && mcnt[i] < 2;
        drn = out_ready && mcnt[i] > 0;
        if (drn) begin
          mdat[i][0] = mdat[i][1];
          mcnt[i]--;
        end
        if (acc) begin
          if (mkill[i] > 0) mkill[i]--;
          else begin
            mdat[i][mcnt[i]] = in_data;
            mcnt[i]++;
          end
        end
      end
    end
  endtask

  task automatic drive(input bit r, input bit f, input bit h, input bit iv,
                       input logic [W-1:0] d, input bit ordy);
    rst = r; flush = f; hold = h; in_valid = iv; in_data = d; out_ready = ordy;
  endtask

  // One clock: check at the falling edge, advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    model_check();
    @(posedge clk);
    model_update();
    #1;
  endtask

  typedef struct {
    bit r, f, h, iv, ordy;
    logic [15:0] din;
    bit ev;
    logic [15:0] ed;
    logic [1:0] eocc;
    bit erdy, ekp;
  } vec_t;

  vec_t tv[26];

  function automatic vec_t mk(bit r, bit f, bit h, bit iv, logic [15:0] din, bit ordy,
                              bit ev, logic [15:0] ed, logic [1:0] eocc, bit erdy, bit ekp);
    vec_t v;
    v.r = r; v.f = f; v.h = h; v.iv = iv; v.din = din; v.ordy = ordy;
    v.ev = ev; v.ed = ed; v.eocc = eocc; v.erdy = erdy; v.ekp = ekp;
    return v;
  endfunction

  initial begin
    for (int i = 0; i < N; i++) begin
      mcnt[i] = 0; mkill[i] = 0; mdat[i][0] = '0; mdat[i][1] = '0;
    end
    drive(1, 0, 0, 0, '0, 0);

    // Expectations for dut_a (shadow 1, bubble 0): r f h iv din ordy | v data occ rdy kp
    tv[0]  = mk(1,0,0,0,16'h0,0, 0,16'h0,0,0,0);
    tv[1]  = mk(0,0,0,1,16'hA,1, 0,16'h0,0,1,0);
    tv[2]  = mk(0,0,0,0,16'h0,1, 1,16'hA,1,1,0);
    tv[3]  = mk(0,0,0,1,16'h1,0, 0,16'h0,0,1,0);
    tv[4]  = mk(0,0,0,1,16'h2,0, 1,16'h1,1,1,0);
    tv[5]  = mk(0,0,0,1,16'h3,0, 1,16'h1,2,0,0);
    tv[6]  = mk(0,0,0,0,16'h0,1, 1,16'h1,2,0,0);
    tv[7]  = mk(0,0,0,0,16'h0,1, 1,16'h2,1,1,0);
    tv[8]  = mk(0,0,0,0,16'h0,0, 0,16'h0,0,1,0);
    tv[9]  = mk(0,0,0,1,16'h7,0, 0,16'h0,0,1,0);
    tv[10] = mk(0,0,0,1,16'h8,0, 1,16'h7,1,1,0);
    tv[11] = mk(0,1,0,0,16'h0,0, 1,16'h7,2,0,0);
    tv[12] = mk(0,0,0,1,16'h5,1, 0,16'h0,0,1,1);
    tv[13] = mk(0,0,0,1,16'h6,1, 0,16'h0,0,1,0);
    tv[14] = mk(0,0,0,0,16'h0,1, 1,16'h6,1,1,0);
    tv[15] = mk(0,0,0,1,16'h9,0, 0,16'h0,0,1,0);
    tv[16] = mk(0,0,1,1,16'hB,1, 0,16'h9,1,0,0);
    tv[17] = mk(0,0,1,1,16'hB,1, 0,16'h9,1,0,0);
    tv[18] = mk(0,0,1,1,16'hB,1, 0,16'h9,1,0,0);
    tv[19] = mk(0,0,0,0,16'h0,1, 1,16'h9,1,1,0);
    tv[20] = mk(0,0,0,0,16'h0,0, 0,16'h0,0,1,0);
    tv[21] = mk(0,0,0,1,16'hC,0, 0,16'h0,0,1,0);
    tv[22] = mk(0,0,0,1,16'hD,0, 1,16'hC,1,1,0);
    tv[23] = mk(1,1,0,1,16'hE,1, 0,16'h0,0,0,0);
    tv[24] = mk(0,0,0,0,16'h0,1, 0,16'h0,0,1,0);
    tv[25] = mk(0,0,0,0,16'h0,1, 0,16'h0,0,1,0);

    for (int k = 0; k < 26; k++) begin
      drive(tv[k].r, tv[k].f, tv[k].h, tv[k].iv, W'(tv[k].din), tv[k].ordy);
      @(negedge clk);
      chk($sformatf("vec%0d out_valid", k), W'(ov[0]), W'(tv[k].ev));
      chk($sformatf("vec%0d out_data", k), od[0], W'(tv[k].ed));
      chk($sformatf("vec%0d occupancy", k), W'(occ[0]), W'(tv[k].eocc));
      chk($sformatf("vec%0d in_ready", k), W'(ir[0]), W'(tv[k].erdy));
      chk($sformatf("vec%0d kill_pending", k), W'(kp[0]), W'(tv[k].ekp));
      model_check();
      @(posedge clk);
      model_update();
      #1;
    end

    // Flush together with hold on dut_b (shadow 2): two beats dropped, third emitted.
    drive(0, 0, 0, 1, W'(16'h30), 0); step();
    drive(0, 1, 1, 1, W'(16'h11), 1); step();
    drive(0, 0, 0, 1, W'(16'h21), 1);
    @(negedge clk);
    chk("fh kill_pending_b", W'(kp[1]), W'(1));
    chk("fh occupancy_b", W'(occ[1]), W'(0));
    chk("fh kill_pending_c", W'(kp[2]), W'(0));
    @(posedge clk); model_update(); #1;
    drive(0, 0, 0, 1, W'(16'h22), 1); step();
    drive(0, 0, 0, 1, W'(16'h23), 1); step();
    drive(0, 0, 0, 0, '0, 1);
    @(negedge clk);
    chk("fh third out_valid_b", W'(ov[1]), W'(1));
    chk("fh third out_data_b", od[1], W'(16'h23));
    chk("fh kill done_b", W'(kp[1]), W'(0));
    @(posedge clk); model_update(); #1;
    step();

    // Flush while kill pending reloads the counter rather than accumulating.
    drive(0, 1, 0, 0, '0, 1); step();
    drive(0, 1, 0, 0, '0, 1); step();
    drive(0, 0, 0, 1, W'(16'h41), 1); step();
    drive(0, 0, 0, 1, W'(16'h42), 1); step();
    drive(0, 0, 0, 1, W'(16'h43), 0);
    @(negedge clk);
    chk("reload kill_pending_b", W'(kp[1]), W'(0));
    chk("reload occupancy_b", W'(occ[1]), W'(0));
    @(posedge clk); model_update(); #1;
    drive(0, 0, 0, 0, '0, 0);
    @(negedge clk);
    chk("reload emitted_b", od[1], W'(16'h43));
    @(posedge clk); model_update(); #1;

    // Random traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) < 7,
            {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()},
            $urandom_range(0, 9) < 6);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
